// File: rtl/patp_control.sv
// rtl/patp_control.sv - PATP fetch/decode/execute sequencer with memory-ready watchdog
module patp_control #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  input  logic [2:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       ir_we_o,
  output logic       pc_inc_o,
  output logic       pc_load_o,
  output logic       addr_sel_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic [2:0] acc_op_o,
  output logic       instr_done_o,
  output logic       busy_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_ERROR
  } state_t;

  localparam logic [2:0] OP_CLEAR = 3'b000;
  localparam logic [2:0] OP_INC   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_JMP   = 3'b100;
  localparam logic [2:0] OP_BNZ   = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_LOAD  = 3'b111;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wd_q, wd_d;
  logic       wd_expire;
  logic       mem_state;
  state_t     boundary_state;

  // The current wait cycle counts as wd_q+1, so expiry looks one ahead.
  assign wd_expire      = (wd_q + 8'd1) == TIMEOUT_C;
  assign mem_state      = (state_q == S_FETCH) || (state_q == S_MEM);
  assign boundary_state = run_i ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wd_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_we_o      = 1'b0;
    pc_inc_o     = 1'b0;
    pc_load_o    = 1'b0;
    addr_sel_o   = 1'b0;
    mem_rd_o     = 1'b0;
    mem_wr_o     = 1'b0;
    acc_op_o     = 3'b000;
    instr_done_o = 1'b0;
    busy_o       = 1'b0;
    err_o        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy_o   = 1'b1;
        mem_rd_o = 1'b1;
        if (mem_ready_i) begin
          ir_we_o  = 1'b1;
          pc_inc_o = 1'b1;
          state_d  = S_DECODE;
        end else if (wd_expire) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        busy_o = 1'b1;
        if (opcode_i == OP_ADD || opcode_i == OP_STORE || opcode_i == OP_LOAD)
          state_d = S_MEM;
        else
          state_d = S_EXEC;
      end
      S_EXEC: begin
        busy_o       = 1'b1;
        instr_done_o = 1'b1;
        state_d      = boundary_state;
        case (opcode_i)
          OP_CLEAR: acc_op_o  = 3'b001;
          OP_INC:   acc_op_o  = 3'b010;
          OP_DEC:   acc_op_o  = 3'b011;
          OP_JMP:   pc_load_o = 1'b1;
          OP_BNZ:   pc_load_o = ~zero_i;
          default:  acc_op_o  = 3'b000;
        endcase
      end
      S_MEM: begin
        busy_o     = 1'b1;
        addr_sel_o = 1'b1;
        if (opcode_i == OP_STORE) mem_wr_o = 1'b1;
        else                      mem_rd_o = 1'b1;
        if (mem_ready_i) begin
          instr_done_o = 1'b1;
          state_d      = boundary_state;
          if (opcode_i == OP_ADD)       acc_op_o = 3'b100;
          else if (opcode_i == OP_LOAD) acc_op_o = 3'b101;
        end else if (wd_expire) begin
          state_d = S_ERROR;
        end
      end
      S_ERROR: begin
        err_o = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fresh entry into a memory-wait state restarts the watchdog; ready wins over expiry.
  always_comb begin
    wd_d = wd_q;
    if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q)
      wd_d = 8'd0;
    else if (mem_state && !mem_ready_i)
      wd_d = wd_q + 8'd1;
  end

endmodule

// File: tb/tb_patp_control.sv
// tb/tb_patp_control.sv - scoreboard bench for patp_control with hand-computed per-cycle outputs
module tb_patp_control;

  logic       clk;
  logic       rst;
  logic       run;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       ir_we, pc_inc, pc_load, addr_sel, mem_rd, mem_wr;
  logic [2:0] acc_op;
  logic       instr_done, busy, err;

  patp_control #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .run_i        (run),
    .opcode_i     (opcode),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .ir_we_o      (ir_we),
    .pc_inc_o     (pc_inc),
    .pc_load_o    (pc_load),
    .addr_sel_o   (addr_sel),
    .mem_rd_o     (mem_rd),
    .mem_wr_o     (mem_wr),
    .acc_op_o     (acc_op),
    .instr_done_o (instr_done),
    .busy_o       (busy),
    .err_o        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {ir_we, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_op[2:0], instr_done, busy, err}
  logic [11:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        stim_done = 1'b0;

  localparam logic [11:0] E_NONE  = 12'b000000_000_000;
  localparam logic [11:0] E_BUSY  = 12'b000000_000_010;
  localparam logic [11:0] E_FOK   = 12'b110010_000_010;
  localparam logic [11:0] E_FWAIT = 12'b000010_000_010;
  localparam logic [11:0] E_ERR   = 12'b000000_000_001;

  function automatic logic [11:0] exec_exp(input logic pcl, input logic [2:0] acc);
    return {2'b00, pcl, 3'b000, acc, 3'b110};
  endfunction

  function automatic logic [11:0] mem_exp(input logic wr, input logic rdy, input logic [2:0] acc);
    return {3'b000, 1'b1, ~wr, wr, acc, rdy, 2'b10};
  endfunction

  task automatic step(input logic r, input logic rn, input logic [2:0] op, input logic z,
                      input logic rdy, input logic [11:0] e, input string nm);
    rst       = r;
    run       = rn;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic [11:0] e;
    logic [11:0] act;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {ir_we, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_op, instr_done, busy, err};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %b required %b", nm, act, e);
        end
        if (mem_rd && mem_wr) begin
          errors++;
          $display("FAIL %s_rdwr_excl: mem_rd=%b mem_wr=%b required not both", nm, mem_rd, mem_wr);
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; run = 1'b0; opcode = 3'b000; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // reset state
    step(1, 0, 3'b000, 0, 0, E_NONE, "reset0");
    step(1, 1, 3'b000, 0, 1, E_NONE, "reset1");
    step(0, 0, 3'b000, 0, 0, E_NONE, "idle_hold");
    // INC then CLEAR, zero-wait, back-to-back
    step(0, 1, 3'b000, 0, 1, E_NONE, "t1_idle");
    step(0, 1, 3'b000, 0, 1, E_FOK, "t1_fetch1");
    step(0, 1, 3'b001, 0, 1, E_BUSY, "t1_decode1");
    step(0, 1, 3'b001, 0, 1, exec_exp(0, 3'b010), "t1_exec_inc");
    step(0, 1, 3'b001, 0, 1, E_FOK, "t1_fetch2");
    step(0, 1, 3'b000, 0, 1, E_BUSY, "t1_decode2");
    step(0, 1, 3'b000, 0, 1, exec_exp(0, 3'b001), "t1_exec_clear");
    // BNZ taken / not taken
    step(0, 1, 3'b000, 0, 1, E_FOK, "t2_fetch1");
    step(0, 1, 3'b101, 0, 1, E_BUSY, "t2_decode1");
    step(0, 1, 3'b101, 0, 1, exec_exp(1, 3'b000), "t2_bnz_taken");
    step(0, 1, 3'b101, 1, 1, E_FOK, "t2_fetch2");
    step(0, 1, 3'b101, 1, 1, E_BUSY, "t2_decode2");
    step(0, 1, 3'b101, 1, 1, exec_exp(0, 3'b000), "t2_bnz_not_taken");
    // LOAD with 3 wait cycles; 4th cycle ready wins against TIMEOUT=4
    step(0, 1, 3'b101, 0, 1, E_FOK, "t3_fetch");
    step(0, 1, 3'b111, 0, 1, E_BUSY, "t3_decode");
    step(0, 1, 3'b111, 0, 0, mem_exp(0, 0, 3'b000), "t3_mem_wait1");
    step(0, 1, 3'b111, 0, 0, mem_exp(0, 0, 3'b000), "t3_mem_wait2");
    step(0, 1, 3'b111, 0, 0, mem_exp(0, 0, 3'b000), "t3_mem_wait3");
    step(0, 1, 3'b111, 0, 1, mem_exp(0, 1, 3'b101), "t3_mem_ready");
    // STORE zero-wait
    step(0, 1, 3'b111, 0, 1, E_FOK, "t4_fetch");
    step(0, 1, 3'b110, 0, 1, E_BUSY, "t4_decode");
    step(0, 1, 3'b110, 0, 1, mem_exp(1, 1, 3'b000), "t4_store");
    // run dropped during FETCH of ADD
    step(0, 0, 3'b110, 0, 1, E_FOK, "t5_fetch");
    step(0, 0, 3'b010, 0, 1, E_BUSY, "t5_decode");
    step(0, 0, 3'b010, 0, 1, mem_exp(0, 1, 3'b100), "t5_add");
    step(0, 0, 3'b010, 0, 1, E_NONE, "t5_idle1");
    step(0, 0, 3'b010, 0, 0, E_NONE, "t5_idle2");
    // FETCH with 2 waits, then DEC and JMP
    step(0, 1, 3'b010, 0, 0, E_NONE, "t6_idle");
    step(0, 1, 3'b010, 0, 0, E_FWAIT, "t6_fetch_wait1");
    step(0, 1, 3'b010, 0, 0, E_FWAIT, "t6_fetch_wait2");
    step(0, 1, 3'b010, 0, 1, E_FOK, "t6_fetch_ok");
    step(0, 1, 3'b011, 0, 1, E_BUSY, "t6_decode_dec");
    step(0, 1, 3'b011, 0, 1, exec_exp(0, 3'b011), "t6_exec_dec");
    step(0, 1, 3'b011, 0, 1, E_FOK, "t6_fetch_jmp");
    step(0, 1, 3'b100, 0, 1, E_BUSY, "t6_decode_jmp");
    step(0, 1, 3'b100, 0, 1, exec_exp(1, 3'b000), "t6_exec_jmp");
    // watchdog: 4 wait cycles in FETCH, then ERROR is sticky
    step(0, 1, 3'b100, 0, 0, E_FWAIT, "t7_wait1");
    step(0, 1, 3'b100, 0, 0, E_FWAIT, "t7_wait2");
    step(0, 1, 3'b100, 0, 0, E_FWAIT, "t7_wait3");
    step(0, 1, 3'b100, 0, 0, E_FWAIT, "t7_wait4");
    step(0, 1, 3'b100, 0, 1, E_ERR, "t7_error1");
    step(0, 0, 3'b100, 0, 0, E_ERR, "t7_error2");
    step(0, 1, 3'b010, 1, 1, E_ERR, "t7_error3");
    step(1, 1, 3'b010, 0, 1, E_NONE, "t7_reset");
    // asynchronous reset during FETCH clears strobes within the cycle
    step(0, 1, 3'b010, 0, 1, E_NONE, "t8_idle");
    step(1, 1, 3'b010, 0, 1, E_NONE, "t8_async_rst");
    step(0, 0, 3'b010, 0, 1, E_NONE, "t8_idle_after");
    stim_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    wait (stim_done);
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: pending %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL sim_timeout: stimulus did not complete");
    $fatal(1);
  end

endmodule
